// File: rtl/gate_vector_checker_if.sv
// Bus bundle between gate_vector_checker and its environment.
// Optional failure-capture signals exist only when GATE_CHK_FAIL_CAPTURE_EN is defined.
interface gate_vector_checker_if;
  logic       start;
  logic       in1;
  logic       in2;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
`ifdef GATE_CHK_FAIL_CAPTURE_EN
  logic       first_fail_vld;
  logic [1:0] first_fail_vec;
`endif

  // Checker side: drives stimulus and status, receives start and the gate response
  modport master (
    input  start, dut_out,
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    output first_fail_vld, first_fail_vec,
`endif
    output in1, in2, busy, done, pass, err_cnt
  );

  // Environment side: requests runs, hosts the gate under test, observes status
  modport slave (
    output start, dut_out,
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    input  first_fail_vld, first_fail_vec,
`endif
    input  in1, in2, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps all four 2-input vectors through a gate under test,
// waits SETTLE_CYC cycles per vector, compares the response to the selected truth
// function and reports a saturating mismatch count.
// Optional macro GATE_CHK_FAIL_CAPTURE_EN adds capture of the first failing vector.
module gate_vector_checker #(
  parameter logic [2:0]  GATE_SEL   = 3'd5,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned PASSES     = 2
) (
  input logic                   clk,
  input logic                   rst,
  gate_vector_checker_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  // Expected gate output for the selected function
  function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      3'd7:    y = a;
      default: y = a;
    endcase
    return y;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] vec_idx_r;
  logic [7:0] pass_cnt_r;
  logic [3:0] settle_cnt_r;
  logic [7:0] err_cnt_r;
  logic       in1_r;
  logic       in2_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;

  logic       start_acc_s;
  logic       settle_end_s;
  logic       last_vec_s;
  logic       mismatch_s;
  logic [7:0] err_next_s;
  logic       busy_next_s;
  logic       done_next_s;
  logic       pass_next_s;

  assign settle_end_s = (settle_cnt_r == SETTLE_LAST);
  assign last_vec_s   = (vec_idx_r == 2'd3) && (pass_cnt_r == PASS_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; start only matters in IDLE and DONE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) next_state_s = DRIVE;
        else           next_state_s = IDLE;
      end
      DRIVE:  next_state_s = SETTLE;
      SETTLE: begin
        if (settle_end_s) next_state_s = SAMPLE;
        else              next_state_s = SETTLE;
      end
      SAMPLE: begin
        if (last_vec_s) next_state_s = DONE;
        else            next_state_s = DRIVE;
      end
      DONE: begin
        if (bus.start) next_state_s = DRIVE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered status outputs and the error counter
  always_comb begin
    start_acc_s = ((state_r == IDLE) || (state_r == DONE)) && bus.start;
    mismatch_s  = (state_r == SAMPLE) && (bus.dut_out != gate_fn(GATE_SEL, in1_r, in2_r));
    if (start_acc_s) begin
      err_next_s = 8'h00;
    end else if (mismatch_s && (err_cnt_r != 8'hFF)) begin
      err_next_s = err_cnt_r + 8'd1;
    end else begin
      err_next_s = err_cnt_r;
    end
    busy_next_s = (next_state_s == DRIVE) || (next_state_s == SETTLE) ||
                  (next_state_s == SAMPLE);
    done_next_s = (next_state_s == DONE);
    pass_next_s = done_next_s && (err_next_s == 8'h00);
  end

  // Status outputs, vector sequencing, stimulus hold and settle timing
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= 8'h00;
      vec_idx_r    <= 2'd0;
      pass_cnt_r   <= 8'd0;
      settle_cnt_r <= 4'd0;
      in1_r        <= 1'b0;
      in2_r        <= 1'b0;
    end else begin
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      pass_r    <= pass_next_s;
      err_cnt_r <= err_next_s;
      if (start_acc_s) begin
        vec_idx_r  <= 2'd0;
        pass_cnt_r <= 8'd0;
      end else if (state_r == SAMPLE) begin
        vec_idx_r <= vec_idx_r + 2'd1;
        if (vec_idx_r == 2'd3) begin
          pass_cnt_r <= pass_cnt_r + 8'd1;
        end
      end
      if (state_r == DRIVE) begin
        {in1_r, in2_r} <= vec_idx_r;
        settle_cnt_r   <= 4'd0;
      end else if (state_r == SETTLE) begin
        settle_cnt_r <= settle_cnt_r + 4'd1;
      end
    end
  end

  assign bus.in1     = in1_r;
  assign bus.in2     = in2_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.pass    = pass_r;
  assign bus.err_cnt = err_cnt_r;

`ifdef GATE_CHK_FAIL_CAPTURE_EN
  logic       first_fail_vld_r;
  logic [1:0] first_fail_vec_r;

  // Latch the first failing vector of a run; cleared by reset or an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_vld_r <= 1'b0;
      first_fail_vec_r <= 2'd0;
    end else if (start_acc_s) begin
      first_fail_vld_r <= 1'b0;
      first_fail_vec_r <= 2'd0;
    end else if (mismatch_s && !first_fail_vld_r) begin
      first_fail_vld_r <= 1'b1;
      first_fail_vec_r <= {in1_r, in2_r};
    end
  end

  assign bus.first_fail_vld = first_fail_vld_r;
  assign bus.first_fail_vec = first_fail_vec_r;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker: randomized fault masks on the
// gate under test, compared against a vector-level reference model.
module tb_gate_vector_checker;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mask_a = 4'b0000;

  gate_vector_checker_if ia();
  gate_vector_checker_if ib();

  gate_vector_checker u_a (.clk(clk), .rst(rst), .bus(ia));
  gate_vector_checker #(.GATE_SEL(3'd0), .SETTLE_CYC(1), .PASSES(100))
    u_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  // Truth table column per function, bit index = {in1,in2}
  function automatic logic ref_gate(input int sel, input logic [1:0] v);
    logic [3:0] col;
    case (sel)
      0:       col = 4'b1000;
      1:       col = 4'b1110;
      2:       col = 4'b0111;
      3:       col = 4'b0001;
      4:       col = 4'b0110;
      5:       col = 4'b1001;
      6:       col = 4'b0011;
      default: col = 4'b1100;
    endcase
    return col[v];
  endfunction

  // Gate models: A is XNOR with per-vector faults from mask_a, B is inverted AND
  assign ia.dut_out = ref_gate(5, {ia.in1, ia.in2}) ^ mask_a[{ia.in1, ia.in2}];
  assign ib.dut_out = ~ref_gate(0, {ib.in1, ib.in2});

  int         busy_a_tot = 0;
  int         busy_b_tot = 0;
  int         run_idx_a  = 0;
  logic [1:0] vec_q[$];

  // Monitor: busy cycle counts and the vector held during each sample cycle
  always @(negedge clk) begin
    if (ia.busy === 1'b1) begin
      if (run_idx_a % 4 == 3) vec_q.push_back({ia.in1, ia.in2});
      run_idx_a++;
      busy_a_tot++;
    end else begin
      run_idx_a = 0;
    end
    if (ib.busy === 1'b1) busy_b_tot++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ia.done === 1'b1) break;
    end
    check("a_done_reached", 32'(ia.done), 32'd1);
  endtask

  task automatic run_a(input logic [3:0] m, input string tag);
    int         b0;
    int         q0;
    int         nerr;
    logic [1:0] fv;
    mask_a = m;
    b0 = busy_a_tot;
    q0 = vec_q.size();
    @(posedge clk); #1 ia.start = 1'b1;
    @(posedge clk); #1 ia.start = 1'b0;
    wait_done_a(200);
    nerr = $countones(m) * 2;
    check({tag, "_busy_cycles"}, 32'(busy_a_tot - b0), 32'd32);
    check({tag, "_vec_count"}, 32'(vec_q.size() - q0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (q0 + i < vec_q.size()) check({tag, "_vec_order"}, 32'(vec_q[q0 + i]), 32'(i % 4));
    end
    check({tag, "_err_cnt"}, 32'(ia.err_cnt), 32'(nerr));
    check({tag, "_pass"}, 32'(ia.pass), 32'(m == 4'b0000));
    check({tag, "_busy_low"}, 32'(ia.busy), 32'd0);
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    fv = 2'd0;
    for (int v = 3; v >= 0; v--) if (m[v]) fv = 2'(v);
    check({tag, "_ff_vld"}, 32'(ia.first_fail_vld), 32'(m != 4'b0000));
    check({tag, "_ff_vec"}, 32'(ia.first_fail_vec), 32'(fv));
`else
    fv = 2'd0;
    if (fv != 2'd0) check({tag, "_ff_unused"}, 32'(fv), 32'd0);
`endif
  endtask

  // Main stimulus sequence
  initial begin
    int n;
    int q0;
    int b0;
    rst      = 1'b1;
    ia.start = 1'b1;
    ib.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in1", 32'(ia.in1), 32'd0);
    check("rst_in2", 32'(ia.in2), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_pass", 32'(ia.pass), 32'd0);
    check("rst_err_cnt", 32'(ia.err_cnt), 32'd0);
    check("rst_b_busy", 32'(ib.busy), 32'd0);
`ifdef GATE_CHK_FAIL_CAPTURE_EN
    check("rst_ff_vld", 32'(ia.first_fail_vld), 32'd0);
`endif
    ia.start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    run_a(4'b0000, "xnor_good");
    run_a(4'b1001, "tied_low");
    for (int r = 0; r < 4; r++) run_a(4'($urandom_range(0, 15)), "random");

    // start held high through DONE restarts immediately with err_cnt cleared
    mask_a = 4'b0011;
    @(posedge clk); #1 ia.start = 1'b1;
    @(posedge clk); #1;
    wait_done_a(200);
    check("hold_err_cnt", 32'(ia.err_cnt), 32'd4);
    check("hold_pass", 32'(ia.pass), 32'd0);
    @(negedge clk);
    check("hold_restart_busy", 32'(ia.busy), 32'd1);
    check("hold_restart_done", 32'(ia.done), 32'd0);
    check("hold_restart_err", 32'(ia.err_cnt), 32'd0);
    check("hold_restart_pass", 32'(ia.pass), 32'd0);
    ia.start = 1'b0;
    wait_done_a(200);
    check("hold_second_err", 32'(ia.err_cnt), 32'd4);

    // start ignored mid-run, then reset aborts the run
    mask_a = 4'b0000;
    @(posedge clk); #1 ia.start = 1'b1;
    q0 = vec_q.size();
    @(posedge clk); #1 ia.start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(negedge clk);
      if (ia.busy === 1'b1) n++;
      ia.start = (n == 5);
    end
    ia.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_cycles", 32'(n), 32'd10);
    check("abort_vec_count", 32'(vec_q.size() - q0), 32'd2);
    if (q0 + 1 < vec_q.size()) check("abort_no_restart", 32'(vec_q[q0 + 1]), 32'd1);
    check("abort_in1", 32'(ia.in1), 32'd0);
    check("abort_in2", 32'(ia.in2), 32'd0);
    check("abort_busy", 32'(ia.busy), 32'd0);
    check("abort_done", 32'(ia.done), 32'd0);
    check("abort_pass", 32'(ia.pass), 32'd0);
    check("abort_err_cnt", 32'(ia.err_cnt), 32'd0);
    run_a(4'($urandom_range(0, 15)), "after_abort");

    // AND checker with an inverted gate over 100 passes saturates the count
    b0 = busy_b_tot;
    @(posedge clk); #1 ib.start = 1'b1;
    @(posedge clk); #1 ib.start = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (ib.done === 1'b1) break;
    end
    check("sat_done", 32'(ib.done), 32'd1);
    check("sat_busy_cycles", 32'(busy_b_tot - b0), 32'd1200);
    check("sat_err_cnt", 32'(ib.err_cnt), 32'd255);
    check("sat_pass", 32'(ib.pass), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL have parameter GATE_SEL, default 3'd5, expected-function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(in1), 7 BUF(in1).
REQ-002 SHALL have parameter SETTLE_CYC, default 2, number of wait cycles between applying a vector and sampling dut_out; legal range 1..15.
REQ-003 SHALL have parameter PASSES, default 2, number of full 4-vector sweeps per run; legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  run request, sampled in IDLE or DONE.
REQ-007 SHALL have port in1  output  1  registered stimulus to the gate under test, first operand.
REQ-008 SHALL have port in2  output  1  registered stimulus to the gate under test, second operand.
REQ-009 SHALL have port dut_out  input  1  response of the gate under test.
REQ-010 SHALL have port busy  output  1  high while a run is in progress.
REQ-011 SHALL have port done  output  1  high from run completion until the next accepted start or reset.
REQ-012 SHALL have port pass  output  1  valid when done is high; 1 if err_cnt==0.
REQ-013 SHALL have port err_cnt  output  8  count of mismatches in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL transition IDLE->DRIVE and DONE->DRIVE on start==1, clearing err_cnt, the vector index, the pass counter and done in the same edge.
REQ-016 SHALL, in DRIVE, load {in1,in2} from a 2-bit vector index ordered 00,01,10,11 (in1 is the MSB), then enter SETTLE.
REQ-017 SHALL remain in SETTLE for exactly SETTLE_CYC cycles with in1/in2 held stable, then enter SAMPLE.
REQ-018 SHALL, in SAMPLE, compare dut_out against the GATE_SEL truth function of the held in1/in2; on mismatch SHALL increment err_cnt, saturating at 8'hFF.
REQ-019 SHALL, after SAMPLE, advance the vector index (wrapping 11->00) and go to DRIVE, unless index==11 and the pass counter==PASSES-1, in which case SHALL go to DONE.
REQ-020 SHALL make each vector take SETTLE_CYC+2 cycles, and busy SHALL be high for exactly 4*PASSES*(SETTLE_CYC+2) cycles per run.
REQ-021 SHALL ignore start while busy is high.
REQ-022 SHALL, in DONE, hold done=1, pass=(err_cnt==0), busy=0, and in1/in2 at their last values.
REQ-023 SHALL keep pass at 0 whenever done is 0.

Reset
REQ-024 SHALL, on rst==1 at a clock edge, force state IDLE and in1=0, in2=0, busy=0, done=0, pass=0, err_cnt=0, vector index 0, pass counter 0.
REQ-025 SHALL let rst asserted mid-run abort the run with no partial result retained; a start after rst deasserts begins a fresh run.
REQ-026 SHALL give rst priority over start when both are high in the same cycle.

Configuration
REQ-027 SHALL, when macro GATE_CHK_FAIL_CAPTURE_EN is defined, add output ports first_fail_vld (1 bit) and first_fail_vec (2 bits, {in1,in2}).
REQ-028 SHALL, with GATE_CHK_FAIL_CAPTURE_EN defined, latch the first failing vector of a run into first_fail_vec and set first_fail_vld, holding both until reset or the next accepted start, which clear them to 0.
REQ-029 SHALL, without GATE_CHK_FAIL_CAPTURE_EN, omit both ports and their registers, leaving all other behaviour identical.

Verification
REQ-030 SHALL cover: rst held 3 cycles with start=1 -> in1=0, in2=0, busy=0, done=0, pass=0, err_cnt=0.
REQ-031 SHALL cover: defaults with a correct XNOR (from NAND) gate, start pulsed once -> busy high exactly 32 cycles, vectors 00,01,10,11 applied twice, done=1, pass=1, err_cnt=0.
REQ-032 SHALL cover: defaults with dut_out tied 0 -> err_cnt=4, pass=0, first_fail_vld=1, first_fail_vec=00 (macro defined).
REQ-033 SHALL cover: start pulsed on cycle 5 of busy, then rst pulsed on cycle 10 -> no restart from the first pulse; after rst all outputs are 0; a later start completes normally.
REQ-034 SHALL cover: GATE_SEL=0 (AND), PASSES=100, with dut_out driven as inverted AND -> err_cnt saturates at 8'hFF, pass=0.
REQ-035 SHALL cover: start held high through DONE -> a new run begins on the next cycle with err_cnt cleared.
